// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: control for a shift-register (SRL) FIFO store.
// Owns occupancy, storage write-enable and read address, and presents a
// first-word-fall-through valid/ready handshake on both sides.
// Optional build macro: SRL_FIFO_CTRL_USEDW_EN adds usedw and almost_full.
module srl_fifo_ctrl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_write,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_din,
   input  logic                  out_read,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_dout,
   output logic                  sr_we,
   output logic [ADDR_WIDTH-1:0] sr_addr,
   output logic [DATA_WIDTH-1:0] sr_din,
   input  logic [DATA_WIDTH-1:0] sr_dout
`ifdef SRL_FIFO_CTRL_USEDW_EN
   ,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic                  almost_full
`endif
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic                  w_in_ready_nxt;
   logic                  w_out_valid_nxt;

   // Fire terms gate on the registered flags, so cnt can never wrap.
   assign w_wr_fire = in_write & r_in_ready;
   assign w_rd_fire = out_read & r_out_valid;

   assign sr_we     = w_wr_fire;
   assign sr_din    = in_din;
   assign sr_addr   = r_addr;
   assign out_dout  = sr_dout;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;

   // Next-state: a write alone grows, a read alone shrinks; both together
   // hold, since the shift plus unchanged pointer consumes the old head.
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_addr_nxt      = r_addr;
      w_in_ready_nxt  = r_in_ready;
      w_out_valid_nxt = r_out_valid;
      if (w_wr_fire && !w_rd_fire) begin
         w_cnt_nxt       = r_cnt + LP_ONE;
         w_out_valid_nxt = 1'b1;
         w_in_ready_nxt  = (w_cnt_nxt < LP_DEPTH);
         if (r_cnt != '0)
            w_addr_nxt = r_addr + 1'b1;
      end else if (w_rd_fire && !w_wr_fire) begin
         w_cnt_nxt       = r_cnt - LP_ONE;
         w_in_ready_nxt  = 1'b1;
         w_out_valid_nxt = (r_cnt > LP_ONE);
         if (r_cnt > LP_ONE)
            w_addr_nxt = r_addr - 1'b1;
      end
   end

   // State registers; reset drops contents immediately (storage untouched).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_addr      <= w_addr_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

`ifdef SRL_FIFO_CTRL_USEDW_EN
   localparam logic [ADDR_WIDTH:0] LP_AF_LVL = LP_DEPTH - LP_ONE;
   localparam logic                LP_AF_RST = (DEPTH == 1);

   logic r_almost_full;

   assign usedw       = r_cnt;
   assign almost_full = r_almost_full;

   // Almost-full tracks the post-update occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_almost_full <= LP_AF_RST;
      else
         r_almost_full <= (w_cnt_nxt >= LP_AF_LVL);
   end
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl with a behavioural SRL store and a queue scoreboard.
module tb_srl_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          in_write;
   logic          in_ready;
   logic [DW-1:0] in_din;
   logic          out_read;
   logic          out_valid;
   logic [DW-1:0] out_dout;
   logic          sr_we;
   logic [AW-1:0] sr_addr;
   logic [DW-1:0] sr_din;
   logic [DW-1:0] sr_dout;
`ifdef SRL_FIFO_CTRL_USEDW_EN
   logic [AW:0]   usedw;
   logic          almost_full;
`endif

   srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_write(in_write), .in_ready(in_ready), .in_din(in_din),
      .out_read(out_read), .out_valid(out_valid), .out_dout(out_dout),
      .sr_we(sr_we), .sr_addr(sr_addr), .sr_din(sr_din), .sr_dout(sr_dout)
`ifdef SRL_FIFO_CTRL_USEDW_EN
      , .usedw(usedw), .almost_full(almost_full)
`endif
   );

   // Shift-register store: newest at index 0.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sr_we) begin
         for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
         mem[0] <= sr_din;
      end
   end
   assign sr_dout = mem[sr_addr];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Per-cycle monitor at the falling edge: flags against model occupancy,
   // then scoreboard pop on read and push on write.
   always @(negedge clk) begin
      if (!reset) begin
         int  sz;
         logic wr, rd;
         sz = exp_q.size();
         wr = in_write && (sz < DEPTH);
         rd = out_read && (sz > 0);
         chk("in_ready", in_ready, sz < DEPTH);
         chk("out_valid", out_valid, sz > 0);
         chk("sr_addr", sr_addr, (sz > 0) ? sz - 1 : 0);
         chk("sr_we", sr_we, wr);
`ifdef SRL_FIFO_CTRL_USEDW_EN
         chk("usedw", usedw, sz);
         chk("almost_full", almost_full, sz >= DEPTH - 1);
`endif
         if (rd) begin
            chk("out_dout", out_dout, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (wr) exp_q.push_back(in_din);
      end
   end

   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
      @(posedge clk);
      #1;
      in_write = w;
      in_din   = d;
      out_read = r;
   endtask

   initial begin
      reset = 1; in_write = 0; in_din = 0; out_read = 0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sr_addr", sr_addr, 0);
      @(posedge clk); #2 reset = 0;
      // idle
      repeat (5) cyc(0, 0, 0);
      // fill, then a write while full
      cyc(1, 8'h0A, 0); cyc(1, 8'h0B, 0); cyc(1, 8'h0C, 0); cyc(1, 8'h0D, 0);
      cyc(1, 8'h0E, 0);
      // drain
      repeat (4) cyc(0, 0, 1);
      cyc(0, 0, 1);  // read when empty
      // two entries, then simultaneous write+read
      cyc(1, 8'h0A, 0); cyc(1, 8'h0B, 0);
      cyc(1, 8'h0C, 1); cyc(1, 8'h0D, 1); cyc(1, 8'h0E, 1);
      cyc(0, 0, 1); cyc(0, 0, 1);
      // full plus write+read: only the read takes effect
      cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
      cyc(1, 8'h55, 1);
      repeat (3) cyc(0, 0, 1);
      // empty with write+read
      cyc(1, 8'h05, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      // three entries, then async reset mid-cycle
      cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0);
      cyc(0, 0, 0);
      #1 reset = 1;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_sr_addr", sr_addr, 0);
      exp_q.delete();
      @(posedge clk); #2 reset = 0;
      cyc(1, 8'h07, 0);
      cyc(0, 0, 1);
      // random traffic
      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat (6) cyc(0, 0, 1);
      cyc(0, 0, 0);
      @(posedge clk); #1;
      chk("final_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
